// File: rtl/name_stream_feeder.sv
// name_stream_feeder: buffers whole names and streams them word by word to the FIB.
// Define NAME_FEEDER_PAD_EN to zero-pad every name to MAX_NAME_LENGTH words.
module name_stream_feeder #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int NAME_DEPTH      = 8,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               wr_valid_in,
    output logic                               wr_ready_out,
    input  logic [WORD_SIZE-1:0]               wr_word_in,
    input  logic                               wr_last_in,
    output logic [WORD_SIZE-1:0]               name_component_out,
    output logic                               comp_valid_out,
    input  logic                               comp_ready_in,
    output logic                               comp_first_out,
    output logic                               comp_last_out,
    output logic [$clog2(MAX_NAME_LENGTH)-1:0] comp_index_out,
    output logic [$clog2(NAME_DEPTH):0]        name_count_out,
    output logic                               overflow_out
);

    localparam int IW = $clog2(MAX_NAME_LENGTH);
    localparam int LW = IW + 1;
    localparam int PW = $clog2(NAME_DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    logic [WORD_SIZE-1:0] mem   [NAME_DEPTH][MAX_NAME_LENGTH];
    logic [LW-1:0]        len_q [NAME_DEPTH];

    state_t               state;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        ld_slot;
    logic [IW-1:0]        wr_idx;
    logic [IW-1:0]        rd_idx;
    logic [IW-1:0]        ld_idx;
    logic [LW-1:0]        ld_pos;
    logic [GW-1:0]        gap_cnt;
    logic [WORD_SIZE-1:0] ld_word;
    logic                 ld_last;
    logic                 discard;
    logic                 wr_fire;
    logic                 wr_full;
    logic                 commit;
    logic                 retire;

    assign wr_ready_out = name_count_out < CW'(NAME_DEPTH);
    assign wr_fire      = wr_valid_in && wr_ready_out;
    assign wr_full      = wr_idx == IW'(MAX_NAME_LENGTH - 1);
    assign commit       = wr_fire && !discard && (wr_last_in || wr_full);
    assign retire       = (state == EMIT) && comp_ready_in && comp_last_out;

    // Load side: a name that hits the length limit without a last marker
    // commits truncated, and the rest of it is swallowed.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr         <= '0;
            wr_idx         <= '0;
            discard        <= 1'b0;
            overflow_out   <= 1'b0;
            name_count_out <= '0;
        end else begin
            if (wr_fire) begin
                if (discard) begin
                    if (wr_last_in) discard <= 1'b0;
                end else if (commit) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    wr_idx <= '0;
                    if (!wr_last_in) begin
                        overflow_out <= 1'b1;
                        discard      <= 1'b1;
                    end
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
            name_count_out <= name_count_out + CW'(commit) - CW'(retire);
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_fire && !discard) mem[wr_ptr][wr_idx] <= wr_word_in;
        if (commit) len_q[wr_ptr] <= {1'b0, wr_idx} + LW'(1);
    end

    // Next word to present, chosen from where the read FSM is heading.
    always_comb begin
        ld_slot = rd_ptr;
        ld_idx  = '0;
        if (state == EMIT) begin
            if (comp_last_out) ld_slot = rd_ptr + PW'(1);
            else               ld_idx  = comp_index_out + IW'(1);
        end else if (state == GAP) begin
            ld_idx = rd_idx;
        end
        ld_pos = {1'b0, ld_idx} + LW'(1);
`ifdef NAME_FEEDER_PAD_EN
        ld_word = (ld_pos <= len_q[ld_slot]) ? mem[ld_slot][ld_idx] : '0;
        ld_last = ld_idx == IW'(MAX_NAME_LENGTH - 1);
`else
        ld_word = mem[ld_slot][ld_idx];
        ld_last = ld_pos == len_q[ld_slot];
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            rd_idx             <= '0;
            gap_cnt            <= '0;
            comp_valid_out     <= 1'b0;
            name_component_out <= '0;
            comp_first_out     <= 1'b0;
            comp_last_out      <= 1'b0;
            comp_index_out     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (name_count_out != '0) begin
                        state              <= EMIT;
                        comp_valid_out     <= 1'b1;
                        name_component_out <= ld_word;
                        comp_first_out     <= ld_idx == '0;
                        comp_last_out      <= ld_last;
                        comp_index_out     <= ld_idx;
                    end
                end
                EMIT: begin
                    if (comp_ready_in) begin
                        if (comp_last_out) begin
                            rd_ptr <= rd_ptr + PW'(1);
                            rd_idx <= '0;
                        end else begin
                            rd_idx <= comp_index_out + IW'(1);
                        end
                        if (GAP_CYCLES > 0) begin
                            state              <= GAP;
                            gap_cnt            <= GW'(GAP_CYCLES - 1);
                            comp_valid_out     <= 1'b0;
                            name_component_out <= '0;
                            comp_first_out     <= 1'b0;
                            comp_last_out      <= 1'b0;
                            comp_index_out     <= '0;
                        end else if (!comp_last_out || name_count_out > CW'(1)) begin
                            name_component_out <= ld_word;
                            comp_first_out     <= ld_idx == '0;
                            comp_last_out      <= ld_last;
                            comp_index_out     <= ld_idx;
                        end else begin
                            state              <= IDLE;
                            comp_valid_out     <= 1'b0;
                            name_component_out <= '0;
                            comp_first_out     <= 1'b0;
                            comp_last_out      <= 1'b0;
                            comp_index_out     <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end else if (rd_idx != '0 || name_count_out != '0) begin
                        state              <= EMIT;
                        comp_valid_out     <= 1'b1;
                        name_component_out <= ld_word;
                        comp_first_out     <= ld_idx == '0;
                        comp_last_out      <= ld_last;
                        comp_index_out     <= ld_idx;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/name_stream_feeder.md
NAME_STREAM_FEEDER -- requirements
Module: name_stream_feeder

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, width of one name component word.
REQ-002 SHALL have parameter MAX_NAME_LENGTH, default 8, maximum words per name.
REQ-003 SHALL have parameter NAME_DEPTH, default 8, number of buffered name slots (power of 2).
REQ-004 SHALL have parameter GAP_CYCLES, default 1, idle cycles inserted after each emitted word (0 = back-to-back).
REQ-005 SHALL have ports: clk_in  input  1  clock; rst_n_in  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports: wr_valid_in  input  1  load word valid; wr_ready_out  output  1  load accepted; wr_word_in  input  WORD_SIZE  word; wr_last_in  input  1  final word of name.
REQ-007 SHALL have ports: name_component_out  output  WORD_SIZE  word to FIB pipeline; comp_valid_out  output  1; comp_ready_in  input  1; comp_first_out  output  1  first word of name; comp_last_out  output  1  last word of name.
REQ-008 SHALL have ports: comp_index_out  output  clog2(MAX_NAME_LENGTH)  word position in name; name_count_out  output  clog2(NAME_DEPTH)+1  committed names; overflow_out  output  1  sticky truncation flag.

Function
REQ-009 Load transfer occurs on clk_in rising edge when wr_valid_in and wr_ready_out are both 1.
REQ-010 wr_ready_out SHALL be 1 iff name_count_out < NAME_DEPTH; a partially loaded name blocks nothing until full.
REQ-011 A name SHALL commit on the transfer carrying wr_last_in=1, or on the MAX_NAME_LENGTH-th word regardless of wr_last_in.
REQ-012 A word transferred when wr_last_in=0 and it is the MAX_NAME_LENGTH-th word SHALL set overflow_out; subsequent words until wr_last_in=1 SHALL be accepted and discarded.
REQ-013 Read FSM states IDLE, EMIT, GAP; IDLE->EMIT when name_count_out>0, first word presented the cycle after commit is registered.
REQ-014 In EMIT, comp_valid_out=1 and outputs SHALL hold stable until comp_ready_in=1.
REQ-015 On accepted word: if not last, EMIT->GAP when GAP_CYCLES>0 else stay EMIT with next word; if last, retire slot and go GAP (GAP_CYCLES>0) or EMIT (next name pending) or IDLE.
REQ-016 GAP SHALL last exactly GAP_CYCLES cycles with comp_valid_out=0, then EMIT or IDLE.
REQ-017 comp_first_out=1 only with comp_index_out=0; comp_last_out=1 only on final emitted word.
REQ-018 Commit and retire in the same cycle SHALL leave name_count_out unchanged.
REQ-019 Slot write and read pointers SHALL wrap modulo NAME_DEPTH.
REQ-020 A single-word name SHALL emit one word with comp_first_out and comp_last_out both 1.

Reset
REQ-021 rst_n_in low SHALL immediately force: FSM IDLE, pointers 0, name_count_out 0, comp_valid_out 0, comp_first_out 0, comp_last_out 0, comp_index_out 0, name_component_out 0, overflow_out 0, wr_ready_out 1 (after deassert).
REQ-022 Reset mid-name SHALL discard partial load and any in-flight emission; buffer contents need not be cleared.

Configuration
REQ-023 Macro NAME_FEEDER_PAD_EN defined: every name SHALL emit exactly MAX_NAME_LENGTH words, words beyond stored length as zero, comp_last_out on index MAX_NAME_LENGTH-1.
REQ-024 Macro NAME_FEEDER_PAD_EN undefined: each name SHALL emit only its stored length.

Verification
REQ-025 Load name 0xA,0xB,0xC (last on 0xC), comp_ready_in=1, GAP_CYCLES=1 -> out 0xA(first,idx0), gap, 0xB(idx1), gap, 0xC(last,idx2); name_count_out 1->0.
REQ-026 Load 8 names with comp_ready_in=0 -> name_count_out=8, wr_ready_out=0; 9th word stalls; one retire restores wr_ready_out=1.
REQ-027 Load 10 words without wr_last_in (MAX_NAME_LENGTH=8) -> overflow_out=1, name of 8 words emitted, words 9-10 dropped.
REQ-028 comp_ready_in toggled 0/1 each cycle during emission -> each word held stable until accepted, no word lost or repeated.
REQ-029 With NAME_FEEDER_PAD_EN, 2-word name 0x1,0x2 -> 0x1,0x2,0,0,0,0,0,0 with comp_last_out on idx7; without, last on 0x2.
REQ-030 Assert rst_n_in low during second word of emission -> all outputs at reset values same cycle, next loaded name emitted from idx0.
